// File: rtl/input_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_deserializer_pkg
//  Description : Shared constants and types for the 3x3 array multiplier
//                byte-stream front end and result serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package input_deserializer_pkg;

  localparam int N_ELEM    = 9;               // elements per 3x3 matrix
  localparam int ELEM_W    = 8;               // bits per element / transfer
  localparam int RES_W     = 18;              // result element width
  localparam int BYTES_IN  = 2 * N_ELEM;      // bytes per input matrix pair
  localparam int BYTES_OUT = 27;              // bytes per serialized result
  localparam int CNT_W     = 5;               // holds 0..BYTES_IN
  localparam int MAT_W     = N_ELEM * ELEM_W; // packed matrix width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    FULL   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/input_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : input_deserializer
//  Description : Collects 18 bytes (9 of matrix A, then 9 of matrix B,
//                row-major) from a valid/ready stream into two packed
//                72-bit matrices and hands them off with a valid/consume
//                handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module input_deserializer
  import input_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MAT_W-1:0]  a_mat,
  output logic [MAT_W-1:0]  b_mat,
  output logic              mat_valid,
  input  logic              consume,
  output logic [CNT_W-1:0]  byte_count
);

  // Counter values of the last A byte and the last byte of the pair; the
  // B element index is the running count minus B_BASE.
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] B_BASE = CNT_W'(N_ELEM);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(BYTES_IN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAT_W-1:0]   a_q, a_d;
  logic [MAT_W-1:0]   b_q, b_d;
  logic               xfer;
  logic [3:0]         elem_idx;
  logic [6:0]         bit_off;

  // Handshake flags decode straight from the state register only.
  assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign mat_valid  = (state_q == FULL);
  assign a_mat      = a_q;
  assign b_mat      = b_q;
  assign byte_count = cnt_q;
  assign xfer       = in_valid && in_ready;

  // Next-state, counter and element write-decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    elem_idx = (state_q == LOAD_B) ? 4'(cnt_q - B_BASE) : cnt_q[3:0];
    bit_off  = {elem_idx, 3'b000};

    if (!enable) begin
      // Abort: discard any partial load but keep matrix contents.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
        LOAD_A: begin
          if (xfer) begin
            a_d[bit_off +: ELEM_W] = in_data;
            cnt_d                  = cnt_q + 1'b1;
            if (cnt_q == LAST_A) state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            b_d[bit_off +: ELEM_W] = in_data;
            cnt_d                  = cnt_q + 1'b1;
            if (cnt_q == LAST_B) state_d = FULL;
          end
        end
        FULL: begin
          // Old contents stay until overwritten by the next load.
          if (consume) begin
            state_d = LOAD_A;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and matrix registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_deserializer
//  Description : Self-checking bench for input_deserializer: a table of
//                single-cycle vectors followed by multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] a_mat;
  logic [71:0] b_mat;
  logic        mat_valid;
  logic        consume = 1'b0;
  logic [4:0]  byte_count;

  int total = 0;
  int bad   = 0;

  logic [71:0] ea = '0;
  logic [71:0] eb = '0;

  localparam logic [71:0] SEQ_A = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] SEQ_B = 72'h12_11_10_0F_0E_0D_0C_0B_0A;

  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic [7:0]  data;
    logic        cons;
    logic        e_rdy;
    logic        e_mv;
    logic [4:0]  e_cnt;
    logic [15:0] e_a16;
  } vec_t;

  vec_t vecs [9];

  input_deserializer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .mat_valid  (mat_valid),
    .consume    (consume),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cnt"}, 72'(byte_count), 72'd0);
    chk({tag, "_mv"},  72'(mat_valid),  72'd0);
    chk({tag, "_rdy"}, 72'(in_ready),   72'd0);
  endtask

  // Sends 18 bytes base..base+17, optionally with an idle cycle after each
  // byte, and optionally pulsing consume with byte number cons_at.
  task automatic load18(input logic [7:0] base, input bit gap, input int cons_at);
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      consume  = (i == cons_at);
      step();
      if (i < 9) ea[8*i +: 8] = in_data;
      else       eb[8*(i-9) +: 8] = in_data;
      chk($sformatf("ld_cnt_%0d", i), 72'(byte_count), 72'(i + 1));
      chk($sformatf("ld_mv_%0d", i),  72'(mat_valid),  72'(i == 17));
      if (gap) begin
        in_valid = 1'b0;
        consume  = 1'b0;
        step();
        chk($sformatf("gap_cnt_%0d", i), 72'(byte_count), 72'(i + 1));
        chk($sformatf("gap_mv_%0d", i),  72'(mat_valid),  72'(i == 17));
      end
    end
    in_valid = 1'b0;
    consume  = 1'b0;
    chk("ld_a",   a_mat,           ea);
    chk("ld_b",   b_mat,           eb);
    chk("ld_rdy", 72'(in_ready),   72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           rst  en   vld  data    cons rdy  mv   cnt    a[15:0]
    vecs[0] = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,5'd0,16'h0000};
    vecs[1] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,5'd0,16'h0000};
    vecs[2] = '{1'b0,1'b1,1'b1,8'h11,1'b0,1'b1,1'b0,5'd1,16'h0011};
    vecs[3] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,5'd1,16'h0011};
    vecs[4] = '{1'b0,1'b1,1'b1,8'h22,1'b0,1'b1,1'b0,5'd2,16'h2211};
    vecs[5] = '{1'b0,1'b0,1'b1,8'h99,1'b0,1'b0,1'b0,5'd0,16'h2211};
    vecs[6] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,5'd0,16'h2211};
    vecs[7] = '{1'b0,1'b1,1'b1,8'h33,1'b1,1'b1,1'b0,5'd1,16'h2233};
    vecs[8] = '{1'b1,1'b1,1'b1,8'h44,1'b0,1'b0,1'b0,5'd0,16'h0000};

    for (int v = 0; v < 9; v++) begin
      reset    = vecs[v].rst;
      enable   = vecs[v].en;
      in_valid = vecs[v].vld;
      in_data  = vecs[v].data;
      consume  = vecs[v].cons;
      step();
      chk($sformatf("vec%0d_rdy", v), 72'(in_ready),    72'(vecs[v].e_rdy));
      chk($sformatf("vec%0d_mv", v),  72'(mat_valid),   72'(vecs[v].e_mv));
      chk($sformatf("vec%0d_cnt", v), 72'(byte_count),  72'(vecs[v].e_cnt));
      chk($sformatf("vec%0d_a", v),   72'(a_mat[15:0]), 72'(vecs[v].e_a16));
    end
    reset = 1'b0; in_valid = 1'b0; consume = 1'b0;

    // Back-to-back load of 0x01..0x12.
    enable = 1'b1;
    ea = '0; eb = '0;
    step();
    chk("start_rdy", 72'(in_ready),   72'd1);
    chk("start_cnt", 72'(byte_count), 72'd0);
    load18(8'h01, 1'b0, -1);
    chk("b2b_a_lo", 72'(a_mat[7:0]),   72'h01);
    chk("b2b_a_hi", 72'(a_mat[71:64]), 72'h09);
    chk("b2b_b_lo", 72'(b_mat[7:0]),   72'h0A);
    chk("b2b_b_hi", 72'(b_mat[71:64]), 72'h12);
    chk("b2b_a",    a_mat,             SEQ_A);
    chk("b2b_b",    b_mat,             SEQ_B);
    chk("b2b_cnt",  72'(byte_count),   72'd18);

    // Same bytes with an idle cycle after each.
    consume = 1'b1;
    step();
    consume = 1'b0;
    chk("cons_cnt", 72'(byte_count), 72'd0);
    chk("cons_mv",  72'(mat_valid),  72'd0);
    chk("cons_rdy", 72'(in_ready),   72'd1);
    chk("cons_hold_a", a_mat, SEQ_A);
    load18(8'h01, 1'b1, -1);
    chk("gap_a", a_mat, SEQ_A);
    chk("gap_b", b_mat, SEQ_B);

    // Producer stalls against FULL, then consume.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int h = 0; h < 5; h++) begin
      step();
      chk($sformatf("hold%0d_a", h),   a_mat,            SEQ_A);
      chk($sformatf("hold%0d_b", h),   b_mat,            SEQ_B);
      chk($sformatf("hold%0d_rdy", h), 72'(in_ready),    72'd0);
      chk($sformatf("hold%0d_cnt", h), 72'(byte_count),  72'd18);
    end
    consume = 1'b1;
    step();
    consume = 1'b0;
    chk("hc_cnt", 72'(byte_count), 72'd0);
    chk("hc_mv",  72'(mat_valid),  72'd0);
    chk("hc_rdy", 72'(in_ready),   72'd1);
    chk("hc_a",   a_mat,           SEQ_A);
    step();
    chk("ff_cnt", 72'(byte_count),  72'd1);
    chk("ff_a0",  72'(a_mat[7:0]),  72'hFF);

    // Partial load (12 bytes total), abort via enable, fresh full load.
    for (int i = 0; i < 11; i++) begin
      in_data = 8'h50 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("part_cnt", 72'(byte_count), 72'd12);
    chk("part_mv",  72'(mat_valid),  72'd0);
    enable = 1'b0;
    step();
    chk_idle("abort");
    enable = 1'b1;
    step();
    chk("reen_rdy", 72'(in_ready),   72'd1);
    chk("reen_cnt", 72'(byte_count), 72'd0);
    load18(8'hA0, 1'b0, -1);
    chk("fresh_a0", 72'(a_mat[7:0]),   72'hA0);
    chk("fresh_b8", 72'(b_mat[71:64]), 72'hB1);

    // consume pulsed during LOAD_B is ignored.
    consume = 1'b1;
    step();
    consume = 1'b0;
    load18(8'h40, 1'b0, 12);
    chk("lb_cons_cnt", 72'(byte_count), 72'd18);

    // enable low beats consume in FULL; matrices are held.
    enable  = 1'b0;
    consume = 1'b1;
    step();
    consume = 1'b0;
    chk_idle("encons");
    chk("encons_a", a_mat, ea);
    chk("encons_b", b_mat, eb);
    enable = 1'b1;
    step();
    chk("encons_rdy", 72'(in_ready), 72'd1);

    // Reset after 5 bytes of a load.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h70 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("mid_cnt", 72'(byte_count), 72'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid_a", a_mat, 72'd0);
    chk("rst_mid_b", b_mat, 72'd0);
    ea = '0; eb = '0;
    step();
    load18(8'hC0, 1'b0, -1);

    // Reset while FULL.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("rst_full");
    chk("rst_full_a", a_mat, 72'd0);
    chk("rst_full_b", b_mat, 72'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_deserializer.md
Name: input_deserializer

Overview:
- Byte-wide receive front end for the 3x3 array multiplier.
- Accepts 18 bytes over a valid/ready stream: 9 elements of matrix A, then 9 elements of matrix B, row-major.
- Assembles them into two packed 72-bit matrix registers and presents them to the multiplier core with a valid/consume handshake.
- Mirror of the 27-byte result serializer on the output side. Sits between the chip input pins and the compute array.

Parameters:
- N_ELEM, 9, elements per matrix (3x3).
- ELEM_W, 8, bits per element and per transferred byte.
- CNT_W, 5, width of the byte counter (must hold 2*N_ELEM = 18).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low aborts any load and returns to IDLE.
- in_data  input  8  incoming element byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
- a_mat  output  72  matrix A; element k (k=0..8, row-major) at [8k+7:8k].
- b_mat  output  72  matrix B, same packing.
- mat_valid  output  1  a_mat/b_mat hold a complete, stable pair.
- consume  input  1  downstream has taken the pair; sampled only while mat_valid=1.
- byte_count  output  5  bytes accepted in the current load, 0..18.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, byte_count=0, a_mat=0, b_mat=0, mat_valid=0.
  - in_ready=0, since it decodes from state.
  - Reset has priority over every other input.
- States: IDLE, LOAD_A, LOAD_B, FULL.
- in_ready=1 exactly when state is LOAD_A or LOAD_B. It is a pure decode of the state register, with no combinational path from in_valid.
- mat_valid=1 exactly when state is FULL.
- IDLE: if enable=1, go to LOAD_A next cycle with byte_count=0. Otherwise stay in IDLE.
- LOAD_A, on each accepted transfer:
  - in_data is written to a_mat element (byte_count), and byte_count increments.
  - When the accepted byte has byte_count=8, next state is LOAD_B.
  - The counter keeps running (9..17) and indexes b_mat by byte_count-9.
- LOAD_B, on each accepted transfer:
  - in_data is written to b_mat element (byte_count-9), and byte_count increments.
  - When byte_count=17 is accepted, next state is FULL and byte_count becomes 18.
- Cycles with in_valid=0 in LOAD_A/LOAD_B change nothing; gaps of any length are legal.
- Latency: mat_valid rises on the clock edge that accepts the 18th byte, i.e. visible in the following cycle. The byte in that cycle is already written.
- FULL: a_mat/b_mat are frozen and in_ready=0. A producer holding in_valid=1 waits; nothing is dropped.
- FULL with consume=1 (and enable=1): next state LOAD_A, byte_count=0, mat_valid=0.
  - Matrix registers keep their old contents until overwritten byte by byte.
- consume is ignored outside FULL.
- enable=0 in any state: next state IDLE, byte_count=0. Matrix contents are held, not cleared. A partially loaded pair is discarded logically; mat_valid stays 0 until a full 18-byte load completes.
- enable=0 and consume=1 in the same FULL cycle: enable wins, go to IDLE.
- byte_count never exceeds 18. No wrap-around is possible because in_ready=0 in FULL.
- Element widths are fixed at 8 bits, with no sign interpretation in this block.

Decomposition:
- Shared multiplier package holds:
  - N_ELEM, ELEM_W, and the result width RES_W=18 (also used by the output serializer).
  - BYTES_IN=18 and BYTES_OUT=27.
  - The state enum {IDLE, LOAD_A, LOAD_B, FULL}.
- No sub-module. Counter, state register and element write-decode live in one module, implemented as an indexed part-select write.

Test Plan:
- Reset, then enable=1, then 18 back-to-back bytes 0x01..0x12 → mat_valid=1 in the cycle after byte 18. Check:
  - a_mat[7:0]=0x01, a_mat[71:64]=0x09.
  - b_mat[7:0]=0x0A, b_mat[71:64]=0x12.
  - byte_count=18, in_ready=0.
- Same 18 bytes with in_valid=0 inserted after every byte → identical a_mat/b_mat. mat_valid rises only after the 18th valid byte, and byte_count tracks accepted bytes only.
- In FULL, hold in_valid=1, in_data=0xFF for 5 cycles, then consume=1 → matrices unchanged during the hold. Next cycle in LOAD_A with byte_count=0. Byte 0xFF is accepted then and written to a_mat[7:0].
- Load 12 bytes, drop enable for 1 cycle, re-enable, send 18 fresh bytes 0xA0..0xB1 → mat_valid stays 0 until the 18th fresh byte. Result a_mat[7:0]=0xA0, b_mat[71:64]=0xB1.
- Assert reset mid-load (after 5 bytes) and again in FULL → next cycle byte_count=0, mat_valid=0, in_ready=0, a_mat=b_mat=0.
- consume=1 pulsed during LOAD_B → ignored: load completes normally and mat_valid rises after byte 18.
